mc_seq_ctrl: RTL and testbench
==============================

# mc_seq_ctrl

Parametrised multi-cycle sequencer for the LoongArch teaching core. It replaces the fixed IF/ID/EXE/MEM/WB state register of the single-memory-cycle design with a handshaked sequencer. Instruction and data SRAM accesses use req/ack with variable wait states and a bus timeout. The block owns the PC and instruction register and emits per-stage enables to the existing decoder, regfile and ALU datapath.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_PC`, 32'h1c000000: PC value loaded on reset.
- `MEM_TIMEOUT`, 255: maximum wait cycles per access before error; legal range 1..65535.
- `CNT_W`, 32: perf counter width (used only with `MC_PERF_CNT_EN`).

- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` out 1: instruction fetch request.
- `inst_addr` out XLEN: fetch address; always equals `pc`.
- `inst_ack` in 1: fetch complete; `inst_rdata` is valid in the same cycle.
- `inst_rdata` in 32: fetched instruction.
- `ir` out 32: latched instruction, fed to the decoder.
- `pc` out XLEN: PC of the instruction in flight.
- `dec_is_load` in 1, `dec_is_store` in 1, `dec_gr_we` in 1: decoder class flags derived from `ir`.
- `br_taken` in 1, `br_target` in XLEN: next-PC selection from the datapath.
- `ex_en` out 1: one-cycle pulse in EXE; datapath latches the ALU result.
- `data_req` out 1, `data_we` out 1: data access request; `data_we` is valid while `data_req` is high.
- `data_ack` in 1, `data_rdata` in 32: data access completion.
- `ld_data` out 32: latched load data.
- `rf_we` out 1: regfile write strobe, one cycle in WB.
- `retire` out 1: one-cycle pulse on the cycle the PC advances.
- `err` out 1: sticky bus-timeout flag.
- `state` out 3: current state, for debug.

## Operation
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, ERR=7.
- IF: `inst_req`=1.
  - On `inst_ack`: `ir`<=`inst_rdata`, go to ID.
- ID: decode settles.
  - If `~dec_gr_we & ~dec_is_load & ~dec_is_store` (b/beq/bne): retire and go to IF.
  - Otherwise go to EXE.
- EXE: `ex_en`=1.
  - Load or store: go to MEM.
  - Otherwise: go to WB.
- MEM: `data_req`=1, `data_we`=`dec_is_store`.
  - On `data_ack` for a load: `ld_data`<=`data_rdata`, go to WB.
  - On `data_ack` for a store: retire and go to IF.
- WB: `rf_we`=`dec_gr_we`; retire and go to IF.
- Retire: `pc`<=`br_taken ? br_target : pc+4` (modulo 2^XLEN; wraps silently), with `retire`=1. This is the only place the PC changes.
- Wait counter: 16 bits.
  - Cleared on entry to IF or MEM.
  - Increments on each cycle in IF/MEM without ack.
  - If the counter equals `MEM_TIMEOUT` and ack is absent: go to ERR, set `err`=1.
  - Ack in the same cycle the counter hits `MEM_TIMEOUT` is accepted normally; ack wins.
- ERR: absorbing state. All strobes and requests are 0 and `pc` is frozen; only reset exits.
- Requests stay high until ack. The memory side must not ack without a request; acks seen outside IF/MEM are ignored.

## Timing
- Reset (asynchronous assert): `pc`=RESET_PC, `state`=IF, `ir`=0, `ld_data`=0, `err`=0. `ex_en`, `rf_we`, `retire` and `data_req` are 0.
  - `inst_req`=1 while in IF, including during reset, because it is a combinational decode of `state`. The memory side must ignore `inst_req` while `resetn`=0.
- Deassertion of `resetn` is synchronised upstream.
- First fetch: `inst_req` is high in the first cycle after release.
- Reset mid-access abandons the access with no further strobes. The PC does not advance.
- Latency with zero-wait memory (ack in the request cycle):
  - ALU or lu12i: IF, ID, EXE, WB = 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - b/beq/bne: 2 cycles.
  - jirl/bl: 4 cycles.
- Each wait cycle adds 1 cycle.
- `retire` and `rf_we` assert in the same cycle for writeback instructions.
- `br_taken` and `br_target` are sampled only in the retire cycle.

## Configuration
- `MC_PERF_CNT_EN` defined: adds outputs `cycle_cnt` and `instret_cnt`, both CNT_W wide.
  - `cycle_cnt` increments every cycle not in ERR.
  - `instret_cnt` increments on `retire`.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- `MC_PERF_CNT_EN` undefined: neither the ports nor the counter logic exist.

## Test plan
- Reset release, zero-wait memory, with `addi.w` at 0x1c000000: `inst_addr`=0x1c000000 in cycle 1; `rf_we` and `retire` in cycle 4; `pc`=0x1c000004 in cycle 5.
- `ld.w` with `data_ack` delayed 3 cycles and `data_rdata`=0xdeadbeef: `data_req` stays high for 4 cycles, `ld_data`=0xdeadbeef, `rf_we` asserts in total cycle 8.
- `beq` taken with `br_target`=0x1c000100: `retire` in cycle 2 with `rf_we`=0, `ex_en` never asserts, next `inst_addr`=0x1c000100.
- `MEM_TIMEOUT`=4 and `inst_ack` held low: `err`=1 and `state`=7 after 5 cycles in IF; no further requests. A second run with ack arriving on the 5th wait cycle completes normally.
- Async reset pulsed mid-MEM of a store: `data_req` drops immediately, `pc`=RESET_PC, `err`=0, and the fetch restarts after release.
- With `MC_PERF_CNT_EN` and `PC`=0xfffffffc retiring sequentially: `pc` wraps to 0, `instret_cnt` increments by 1, and `cycle_cnt` matches the bench cycle count.

Source files
------------

// File: rtl/mc_seq_ctrl.sv
// Handshaked multi-cycle sequencer: owns PC/IR and emits per-stage enables.
// Optional perf counters (cycle_cnt, instret_cnt) are built when MC_PERF_CNT_EN is defined.
module mc_seq_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 'h1c000000,
    parameter int unsigned     MEM_TIMEOUT = 255,
    parameter int unsigned     CNT_W       = 32
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_ack,
    input  logic [31:0]     inst_rdata,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] pc,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_gr_we,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            ex_en,
    output logic            data_req,
    output logic            data_we,
    input  logic            data_ack,
    input  logic [31:0]     data_rdata,
    output logic [31:0]     ld_data,
    output logic            rf_we,
    output logic            retire,
    output logic            err,
    output logic [2:0]      state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4,
        StErr = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     ld_data_q, ld_data_d;
    logic            err_q, err_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;
    logic            timeout;

    assign timeout = (wait_cnt_q == 16'(MEM_TIMEOUT));

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ld_data_d  = ld_data_q;
        err_d      = err_q;
        // Anything other than an unacked IF/MEM cycle clears the counter, so it
        // is always zero on entry to IF or MEM.
        wait_cnt_d = '0;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        ex_en      = 1'b0;
        rf_we      = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            StIf: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    ir_d    = inst_rdata;
                    state_d = StId;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StId: begin
                if (!dec_gr_we && !dec_is_load && !dec_is_store) begin
                    retire  = 1'b1;
                    state_d = StIf;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                ex_en   = 1'b1;
                state_d = (dec_is_load || dec_is_store) ? StMem : StWb;
            end
            StMem: begin
                data_req = 1'b1;
                data_we  = dec_is_store;
                if (data_ack) begin
                    if (dec_is_store) begin
                        retire  = 1'b1;
                        state_d = StIf;
                    end else begin
                        ld_data_d = data_rdata;
                        state_d   = StWb;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StWb: begin
                rf_we   = dec_gr_we;
                retire  = 1'b1;
                state_d = StIf;
            end
            StErr: begin
            end
            default: state_d = StErr;
        endcase

        pc_d = pc_q;
        if (retire) begin
            pc_d = br_taken ? br_target : pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIf;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ld_data_q  <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ld_data_q  <= ld_data_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ld_data   = ld_data_q;
    assign err       = err_q;
    assign state     = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != StErr) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (retire) begin
                instret_cnt_q <= instret_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    // CNT_W only sizes the perf counters.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: per-instruction latency/strobe model with random
// wait states, plus directed reset, branch, wrap, mid-access reset and timeout cases.
module tb_mc_seq_ctrl;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int unsigned TIMEOUT  = 4;
    localparam int unsigned CNT_W    = 32;

    localparam int KAlu    = 0;
    localparam int KLoad   = 1;
    localparam int KStore  = 2;
    localparam int KBranch = 3;

    logic            clk;
    logic            resetn;
    logic            inst_req;
    logic [31:0]     inst_addr;
    logic            inst_ack;
    logic [31:0]     inst_rdata;
    logic [31:0]     ir;
    logic [31:0]     pc;
    logic            dec_is_load;
    logic            dec_is_store;
    logic            dec_gr_we;
    logic            br_taken;
    logic [31:0]     br_target;
    logic            ex_en;
    logic            data_req;
    logic            data_we;
    logic            data_ack;
    logic [31:0]     data_rdata;
    logic [31:0]     ld_data;
    logic            rf_we;
    logic            retire;
    logic            err;
    logic [2:0]      state;
`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
`endif

    mc_seq_ctrl #(
        .XLEN        (XLEN),
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_ack     (inst_ack),
        .inst_rdata   (inst_rdata),
        .ir           (ir),
        .pc           (pc),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_gr_we    (dec_gr_we),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .ex_en        (ex_en),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_ack     (data_ack),
        .data_rdata   (data_rdata),
        .ld_data      (ld_data),
        .rf_we        (rf_we),
        .retire       (retire),
        .err          (err),
        .state        (state)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One instruction end to end; called and returns at a falling edge with the DUT in IF.
    task automatic run_instr(input int kind, input int iw, input int dw, input logic taken,
                             input logic [31:0] target, input logic [31:0] ldval);
        int          t_exp;
        int          c;
        int          ireq_n;
        int          dreq_n;
        int          ex_n;
        int          rf_n;
        int          retire_at;
        logic        rf_at_retire;
        logic        we_ok;
        logic        mem;
        logic [31:0] word;
`ifdef MC_PERF_CNT_EN
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] i0;
        c0 = cycle_cnt;
        i0 = instret_cnt;
`endif
        word         = $urandom;
        mem          = (kind == KLoad) || (kind == KStore);
        dec_is_load  = (kind == KLoad);
        dec_is_store = (kind == KStore);
        dec_gr_we    = (kind == KAlu) || (kind == KLoad);
        br_taken     = taken;
        br_target    = target;
        t_exp = iw + 2 + ((kind == KBranch) ? 0 :
                          1 + (mem ? dw + 1 : 0) + ((kind == KStore) ? 0 : 1));

        check_eq("inst_addr", inst_addr, exp_pc);
        c = 0; ireq_n = 0; dreq_n = 0; ex_n = 0; rf_n = 0; retire_at = 0;
        rf_at_retire = 1'b0; we_ok = 1'b1;
        while (retire_at == 0 && c < t_exp + 4) begin
            c++;
            inst_ack   = inst_req && (ireq_n == iw);
            inst_rdata = inst_ack ? word : $urandom;
            data_ack   = data_req && (dreq_n == dw);
            data_rdata = data_ack ? ldval : $urandom;
            if (inst_req) ireq_n++;
            if (data_req) begin
                dreq_n++;
                if (data_we !== (kind == KStore)) we_ok = 1'b0;
            end
            #1;
            if (ex_en) ex_n++;
            if (rf_we) rf_n++;
            if (retire) begin
                retire_at    = c;
                rf_at_retire = rf_we;
            end
            @(negedge clk);
        end
        inst_ack = 1'b0;
        data_ack = 1'b0;

        exp_pc = taken ? target : exp_pc + 32'd4;
        check_eq("retire_cycle", retire_at, t_exp);
        check_eq("rf_we_at_retire", rf_at_retire, dec_gr_we);
        check_eq("rf_we_pulses", rf_n, dec_gr_we ? 1 : 0);
        check_eq("ex_en_pulses", ex_n, (kind == KBranch) ? 0 : 1);
        check_eq("data_req_cycles", dreq_n, mem ? dw + 1 : 0);
        check_eq("data_we", we_ok, 1'b1);
        check_eq("pc", pc, exp_pc);
        check_eq("ir", ir, word);
        if (kind == KLoad) check_eq("ld_data", ld_data, ldval);
`ifdef MC_PERF_CNT_EN
        check_eq("cycle_cnt_delta", cycle_cnt - c0, t_exp);
        check_eq("instret_cnt_delta", instret_cnt - i0, 1);
`endif
    endtask

    task automatic check_in_reset();
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_state", state, 3'd0);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_ld_data", ld_data, 32'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_strobes", {ex_en, rf_we, retire, data_req}, 4'b0000);
        check_eq("rst_inst_req", inst_req, 1'b1);
`ifdef MC_PERF_CNT_EN
        check_eq("rst_cycle_cnt", cycle_cnt, 0);
        check_eq("rst_instret_cnt", instret_cnt, 0);
`endif
    endtask

    initial begin
        logic [3:0]  strobes;
        logic [2:0]  st_seen;
        n_checks = 0;
        n_errors = 0;
        inst_ack = 1'b0; inst_rdata = '0; data_ack = 1'b0; data_rdata = '0;
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_gr_we = 1'b0;
        br_taken = 1'b0; br_target = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1 check_in_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        exp_pc = RESET_PC;

        // addi.w, ld.w with 3 data waits, taken beq, ack on the last legal wait cycle
        run_instr(KAlu, 0, 0, 1'b0, 32'h0, 32'h0);
        run_instr(KLoad, 0, 3, 1'b0, 32'h0, 32'hdeadbeef);
        run_instr(KBranch, 0, 0, 1'b1, 32'h1c000100, 32'h0);
        run_instr(KAlu, 0, 0, 1'b0, 32'h0, 32'h0);
        run_instr(KLoad, TIMEOUT, TIMEOUT, 1'b0, 32'h0, 32'h13572468);
        run_instr(KStore, TIMEOUT, TIMEOUT, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int          k;
            logic        tk;
            logic [31:0] tgt;
            k   = $urandom_range(0, 3);
            tk  = ((k == KAlu) || (k == KBranch)) ? 1'($urandom_range(0, 1)) : 1'b0;
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            run_instr(k, $urandom_range(0, TIMEOUT), $urandom_range(0, TIMEOUT), tk, tgt,
                      $urandom);
        end

        // PC wraps from the top of the address space
        run_instr(KBranch, 0, 0, 1'b1, 32'hfffffffc, 32'h0);
        run_instr(KAlu, 1, 0, 1'b0, 32'h0, 32'h0);
        check_eq("pc_wrap", pc, 32'h0);

        // Reset in the middle of a store's MEM phase
        dec_is_load = 1'b0; dec_is_store = 1'b1; dec_gr_we = 1'b0; br_taken = 1'b0;
        inst_ack = 1'b1; inst_rdata = $urandom;
        @(negedge clk);
        inst_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check_eq("mid_store_req", data_req, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_data_req", data_req, 1'b0);
        check_eq("mid_rst_pc", pc, RESET_PC);
        check_eq("mid_rst_err", err, 1'b0);
        check_eq("mid_rst_state", state, 3'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_pc = RESET_PC;
        run_instr(KAlu, 0, 0, 1'b0, 32'h0, 32'h0);

        // Fetch never acked: five IF cycles then ERR, absorbing
        for (int i = 0; i <= TIMEOUT; i++) begin
            inst_ack = 1'b0;
            @(negedge clk);
        end
        check_eq("timeout_state", state, 3'd7);
        check_eq("timeout_err", err, 1'b1);
`ifdef MC_PERF_CNT_EN
        begin
            logic [CNT_W-1:0] c_err;
            c_err = cycle_cnt;
`endif
        strobes = 4'b0000;
        st_seen = 3'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            strobes = strobes | {inst_req, data_req, retire, rf_we | ex_en};
            if (state != 3'd7) st_seen = state;
            @(negedge clk);
        end
        check_eq("err_strobes", strobes, 4'b0000);
        check_eq("err_state_held", st_seen, 3'd7);
        check_eq("err_pc_frozen", pc, exp_pc);
        check_eq("err_sticky", err, 1'b1);
`ifdef MC_PERF_CNT_EN
            check_eq("err_cycle_cnt_frozen", cycle_cnt, c_err);
        end
`endif
        resetn = 1'b0;
        #1 check_eq("err_cleared_by_reset", err, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        exp_pc = RESET_PC;
        run_instr(KStore, 1, 2, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
